reg_bank_xchg: RTL and testbench

- 32x32 MIPS general-purpose register bank for the multicycle datapath.
- Its write port consumes the register-data mux output. Its two combinational read ports feed registers A/B.
- Built-in two-cycle swap sequencer implements XCHG, so the datapath writes two registers without extra control-unit states.
- Sits between the register-data mux (write side) and the A/B operand registers (read side).

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_xchg_seq.sv | 84 ++++++++
 rtl/reg_bank_xchg.sv | 78 +++++++
 tb/tb_reg_bank_xchg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and swap-state encoding for the XCHG-capable register bank.
package reg_bank_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 5;
    localparam int unsigned DEF_SP_IDX  = 29;
    localparam int unsigned DEF_SP_INIT = 227;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWAP_A = 2'd1,
        SWAP_B = 2'd2
    } swap_state_e;

endpackage

// File: rtl/reg_bank_xchg_seq.sv
// Two-cycle swap sequencer: captures operands and their values, then emits
// two writes (ra <- old rb, then rb <- old ra) and a one-cycle done pulse.
module xchg_seq
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    input  logic [DATA_W-1:0] val_a_i,
    input  logic [DATA_W-1:0] val_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    swap_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [DATA_W-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        tmp_a_d   = tmp_a_q;
        tmp_b_d   = tmp_b_q;
        done_d    = 1'b0;
        wr_en_o   = 1'b0;
        wr_addr_o = ra_q;
        wr_data_o = tmp_b_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ra_d    = ra_i;
                    rb_d    = rb_i;
                    tmp_a_d = val_a_i;
                    tmp_b_d = val_b_i;
                    state_d = SWAP_A;
                end
            end
            SWAP_A: begin
                wr_en_o = 1'b1;
                state_d = SWAP_B;
            end
            SWAP_B: begin
                wr_en_o   = 1'b1;
                wr_addr_o = rb_q;
                wr_data_o = tmp_a_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: rtl/reg_bank_xchg.sv
// MIPS 32x32 register bank with two combinational read ports, one write port
// and a built-in XCHG swap sequencer sharing that write port.
module reg_bank_xchg
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned SP_IDX  = DEF_SP_IDX,
    parameter int unsigned SP_INIT = DEF_SP_INIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              XCHGStart,
    output logic              XCHGBusy,
    output logic              XCHGDone
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] val_a, val_b;
    logic              swap_wr_en;
    logic [ADDR_W-1:0] swap_wr_addr;
    logic [DATA_W-1:0] swap_wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Capture sees a write landing on the same edge, so forward it here.
    assign val_a = (RegWrite && (WriteReg == ReadReg1) && (ReadReg1 != '0)) ? WriteData : regs_q[ReadReg1];
    assign val_b = (RegWrite && (WriteReg == ReadReg2) && (ReadReg2 != '0)) ? WriteData : regs_q[ReadReg2];

    xchg_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (reset),
        .start_i   (XCHGStart),
        .ra_i      (ReadReg1),
        .rb_i      (ReadReg2),
        .val_a_i   (val_a),
        .val_b_i   (val_b),
        .busy_o    (XCHGBusy),
        .done_o    (XCHGDone),
        .wr_en_o   (swap_wr_en),
        .wr_addr_o (swap_wr_addr),
        .wr_data_o (swap_wr_data)
    );

    always_comb begin
        wr_en   = swap_wr_en | (RegWrite & ~XCHGBusy);
        wr_addr = swap_wr_en ? swap_wr_addr : WriteReg;
        wr_data = swap_wr_en ? swap_wr_data : WriteData;
    end

    // Register 0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign ReadData1 = regs_q[ReadReg1];
    assign ReadData2 = regs_q[ReadReg2];

endmodule

// File: tb/tb_reg_bank_xchg.sv
// Scoreboard bench for reg_bank_xchg: register writes, swaps, edge swaps, abort.
module tb_reg_bank_xchg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [31:0] ReadData1, ReadData2;
    logic        XCHGStart = 1'b0;
    logic        XCHGBusy, XCHGDone;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    reg_bank_xchg dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .XCHGStart (XCHGStart),
        .XCHGBusy  (XCHGBusy),
        .XCHGDone  (XCHGDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [4:0] idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ReadReg1 = e.idx;
            #1;
            chk(e.tag, ReadData1, e.val);
            $display("txn read %s reg%0d=%h", e.tag, e.idx, ReadData1);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = addr;
        WriteData = data;
        @(negedge clk);
        RegWrite  = 1'b0;
        $display("txn write reg%0d<=%h", addr, data);
    endtask

    task automatic swap(input logic [4:0] a, input logic [4:0] b, input logic cw,
                        input logic [4:0] wa, input logic [31:0] wd, input bit hold);
        int busy_n;
        int done_n;
        int first_done;
        busy_n = 0;
        done_n = 0;
        first_done = 0;
        @(negedge clk);
        ReadReg1  = a;
        ReadReg2  = b;
        XCHGStart = 1'b1;
        RegWrite  = cw;
        WriteReg  = wa;
        WriteData = wd;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            RegWrite = 1'b0;
            if (!(hold && k == 1)) XCHGStart = 1'b0;
            if (XCHGBusy) busy_n++;
            if (XCHGDone) begin
                done_n++;
                if (first_done == 0) first_done = k;
            end
        end
        chk("swap_busy_cycles", busy_n, 2);
        chk("swap_done_count", done_n, 1);
        chk("swap_done_cycle", first_done, 3);
        $display("txn swap r%0d<->r%0d busy=%0d done=%0d", a, b, busy_n, done_n);
    endtask

    initial begin
        int done_n;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset visible before any clock edge.
        wr(29, 32'h1);
        wr(5, 32'h5);
        @(negedge clk);
        ReadReg1 = 29;
        ReadReg2 = 5;
        #2 reset = 1'b0;
        #1;
        chk("rst_sp", ReadData1, 32'd227);
        chk("rst_r5", ReadData2, 32'd0);
        chk("rst_busy", XCHGBusy, 1'b0);
        chk("rst_done", XCHGDone, 1'b0);
        $display("txn reset sp=%0d r5=%h", ReadData1, ReadData2);
        @(negedge clk);
        reset = 1'b1;

        // Write then read; value must not appear before the edge.
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 8;
        WriteData = 32'hDEADBEEF;
        ReadReg1  = 8;
        #1;
        chk("wr_not_before", ReadData1, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        push("wr_r8", 8, 32'hDEADBEEF);
        wr(0, 32'h1234);
        push("wr_r0", 0, 32'h0);
        drain();

        wr(3, 32'h11);
        wr(4, 32'h22);
        swap(3, 4, 1'b0, 0, 0, 1'b0);
        push("swap_r3", 3, 32'h22);
        push("swap_r4", 4, 32'h11);
        drain();

        wr(7, 32'h66);
        swap(6, 7, 1'b1, 6, 32'h55, 1'b0);
        push("cw_r6", 6, 32'h66);
        push("cw_r7", 7, 32'h55);
        drain();

        wr(9, 32'h99);
        swap(9, 9, 1'b0, 0, 0, 1'b0);
        push("same_r9", 9, 32'h99);
        drain();

        wr(10, 32'hAA);
        swap(0, 10, 1'b0, 0, 0, 1'b0);
        push("zero_r10", 10, 32'h0);
        push("zero_r0", 0, 32'h0);
        drain();

        wr(11, 32'h1);
        wr(12, 32'h2);
        swap(11, 12, 1'b0, 0, 0, 1'b1);
        push("hold_r11", 11, 32'h2);
        push("hold_r12", 12, 32'h1);
        drain();

        // Reset during SWAP_B aborts the swap.
        wr(3, 32'h33);
        wr(4, 32'h44);
        @(negedge clk);
        ReadReg1  = 3;
        ReadReg2  = 4;
        XCHGStart = 1'b1;
        @(negedge clk);
        XCHGStart = 1'b0;
        @(negedge clk);
        chk("abort_in_swap_b", XCHGBusy, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_busy", XCHGBusy, 1'b0);
        chk("abort_done", XCHGDone, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (XCHGDone) done_n++;
        end
        chk("abort_no_done", done_n, 0);
        $display("txn abort done_seen=%0d", done_n);
        push("abort_r3", 3, 32'h0);
        push("abort_r4", 4, 32'h0);
        push("abort_r8", 8, 32'h0);
        push("abort_sp", 29, 32'd227);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
